// File: rtl/encrypt_sequencer.sv
// Hardware sequencer for the program-1 message encryption: loads the preamble length, LFSR taps
// and seed from data memory, then writes 64 LFSR-whitened plaintext bytes to the output area.
module encrypt_sequencer #(
  parameter int unsigned NBYTES   = 64,
  parameter logic [7:0]  MSG_BASE = 8'd0,
  parameter logic [7:0]  OUT_BASE = 8'd64,
  parameter logic [7:0]  CFG_PRE  = 8'd61,
  parameter logic [7:0]  CFG_TAP  = 8'd62,
  parameter logic [7:0]  CFG_SEED = 8'd63
) (
  input  logic       clk_i,
  input  logic       init_ni,
  input  logic       req_i,
  output logic       ack_o,
  output logic       busy_o,
  output logic [7:0] mem_addr_o,
  output logic       mem_we_o,
  output logic [7:0] mem_wdata_o,
  input  logic [7:0] mem_rdata_i
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLdPre  = 3'd1;
  localparam logic [2:0] StLdTap  = 3'd2;
  localparam logic [2:0] StLdSeed = 3'd3;
  localparam logic [2:0] StRd     = 3'd4;
  localparam logic [2:0] StWr     = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  localparam logic [6:0] LastIdx = 7'(NBYTES - 1);

  logic [2:0] state_q, state_d;
  logic       armed_q, armed_d;
  logic [7:0] pre_len_q, pre_len_d;
  logic [6:0] taps_q, taps_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] idx_q, idx_d;
  logic [7:0] ptxt_q, ptxt_d;

  logic       in_preamble;
  logic [7:0] msg_off;
  logic       running;

  // Preamble bytes are zero plaintext; afterwards the message is read with 8-bit wrap.
  assign in_preamble = ({1'b0, idx_q} < pre_len_q);
  assign msg_off     = {1'b0, idx_q} - pre_len_q;
  assign running     = (state_q >= StLdPre) && (state_q <= StWr);

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    pre_len_d = pre_len_q;
    taps_d    = taps_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    ptxt_d    = ptxt_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = StLdPre;
        end
      end
      StLdPre: begin
        pre_len_d = mem_rdata_i;
        state_d   = StLdTap;
      end
      StLdTap: begin
        taps_d  = mem_rdata_i[6:0];
        state_d = StLdSeed;
      end
      StLdSeed: begin
        // An all-zero seed would lock the LFSR, so it is replaced by 1.
        lfsr_d  = (mem_rdata_i[6:0] == 7'd0) ? 7'h01 : mem_rdata_i[6:0];
        idx_d   = 7'd0;
        state_d = StRd;
      end
      StRd: begin
        ptxt_d  = in_preamble ? 8'h00 : mem_rdata_i;
        state_d = StWr;
      end
      StWr: begin
        lfsr_d  = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
        idx_d   = idx_q + 7'd1;
        state_d = (idx_q == LastIdx) ? StDone : StRd;
      end
      StDone: begin
        if (req_i) begin
          armed_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (running && req_i) begin
      state_d = StIdle;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge init_ni) begin
    if (!init_ni) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      pre_len_q <= 8'd0;
      taps_q    <= 7'd0;
      lfsr_q    <= 7'd0;
      idx_q     <= 7'd0;
      ptxt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      pre_len_q <= pre_len_d;
      taps_q    <= taps_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      ptxt_q    <= ptxt_d;
    end
  end

  always_comb begin
    mem_addr_o  = 8'd0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 8'd0;
    case (state_q)
      StLdPre:  mem_addr_o = CFG_PRE;
      StLdTap:  mem_addr_o = CFG_TAP;
      StLdSeed: mem_addr_o = CFG_SEED;
      StRd:     mem_addr_o = in_preamble ? MSG_BASE : (MSG_BASE + msg_off);
      StWr: begin
        mem_addr_o  = OUT_BASE + {1'b0, idx_q};
        mem_we_o    = 1'b1;
        mem_wdata_o = {1'b0, ptxt_q[6:0] ^ lfsr_q};
      end
      default: ;
    endcase
  end

  assign busy_o = running;
  assign ack_o  = (state_q == StDone);

endmodule
